psram_apb_wb_bridge: RTL and testbench

//  APB slave to Wishbone master bridge that drives the PSRAM controller's Wishbone port.

---
 rtl/psram_apb_wb_bridge.sv | 190 +++++++++++++++++++
 tb/tb_psram_apb_wb_bridge.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_apb_wb_bridge.sv
// psram_apb_wb_bridge
//   APB slave -> Wishbone master bridge in front of the PSRAM controller.
//   Each APB write strobe pattern is broken into byte-select chunks the
//   controller accepts (1111, 0011, 1100 or a single byte). Each chunk gets
//   its own WB cycle, with a one-cycle idle gap between chunks. Reads are
//   always full words. Accesses outside the PSRAM window, and WB chunks
//   that are never acknowledged, complete with PSLVERR.
// Ports
//   clk_i, rst_i           clock, asynchronous active-high reset
//   paddr..pstrb           APB request (only the access phase is used)
//   pready/prdata/pslverr  APB completion: a single-cycle pulse with its data
//   adr_o..we_o, dat_o     WB master request (stb_o mirrors cyc_o)
//   dat_i, ack_i           WB response
module psram_apb_wb_bridge #(
  parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
  parameter int          SIZE_LOG2      = 24,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  output logic        pready,
  output logic [31:0] prdata,
  output logic        pslverr,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  output logic [3:0]  sel_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  input  logic        ack_i
);

  localparam logic [31:0] OFS_MASK = 32'((64'd1 << SIZE_LOG2) - 64'd1);
  localparam int          CW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_GAP, S_DONE} state_t;

  state_t        r_state, w_state;
  logic [3:0]    r_mask, w_mask;
  logic [3:0]    r_sel, w_sel;
  logic [31:0]   r_adr, w_adr;
  logic [31:0]   r_dat, w_dat;
  logic          r_we, w_we;
  logic          r_cyc, w_cyc;
  logic          r_pready, w_pready;
  logic          r_pslverr, w_pslverr;
  logic [31:0]   r_prdata, w_prdata;
  logic [CW-1:0] r_cnt, w_cnt;
  logic          w_in_win;

  // Next chunk to issue from the remaining strobe mask: a full word goes in
  // one shot; otherwise take the lowest byte, paired with its neighbour only
  // when the two form an aligned halfword.
  function automatic logic [3:0] f_chunk(input logic [3:0] m);
    logic [3:0] c;
    if (m == 4'b1111)  c = 4'b1111;
    else if (m[0])     c = m[1] ? 4'b0011 : 4'b0001;
    else if (m[1])     c = 4'b0010;
    else if (m[2])     c = m[3] ? 4'b1100 : 4'b0100;
    else if (m[3])     c = 4'b1000;
    else               c = 4'b0000;
    return c;
  endfunction

  assign w_in_win = ((paddr ^ BASE_ADDR) & ~OFS_MASK) == 32'h0;

  always_comb begin
    w_state   = r_state;
    w_mask    = r_mask;
    w_sel     = r_sel;
    w_adr     = r_adr;
    w_dat     = r_dat;
    w_we      = r_we;
    w_cyc     = r_cyc;
    w_pready  = 1'b0;
    w_pslverr = r_pslverr;
    w_prdata  = r_prdata;
    w_cnt     = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (psel && penable) begin
          w_pslverr = 1'b0;
          w_adr     = (BASE_ADDR & ~OFS_MASK) | (paddr & OFS_MASK & 32'hFFFF_FFFC);
          w_dat     = pwdata;
          w_cnt     = '0;
          if (!w_in_win) begin
            w_pslverr = 1'b1;
            w_pready  = 1'b1;
            w_state   = S_DONE;
          end else if (!pwrite) begin
            w_we    = 1'b0;
            w_sel   = 4'b1111;
            w_mask  = 4'b1111;
            w_cyc   = 1'b1;
            w_state = S_XFER;
          end else if (pstrb == 4'b0000) begin
            w_pready = 1'b1;
            w_state  = S_DONE;
          end else begin
            w_we    = 1'b1;
            w_mask  = pstrb;
            w_sel   = f_chunk(pstrb);
            w_cyc   = 1'b1;
            w_state = S_XFER;
          end
        end
      end
      S_XFER: begin
        if (ack_i) begin
          w_mask = r_mask & ~r_sel;
          w_cyc  = 1'b0;
          if (!r_we) w_prdata = dat_i;
          if (!r_we || w_mask == 4'b0000) begin
            w_pready = 1'b1;
            w_state  = S_DONE;
          end else begin
            w_state = S_GAP;
          end
        end else if (r_cnt == CNT_LAST) begin
          // Stalled controller: abandon this and any remaining chunks.
          w_cyc     = 1'b0;
          w_mask    = 4'b0000;
          w_pslverr = 1'b1;
          w_pready  = 1'b1;
          w_state   = S_DONE;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_GAP: begin
        // One idle cycle lets the controller return to idle between chunks.
        w_sel   = f_chunk(r_mask);
        w_cyc   = 1'b1;
        w_cnt   = '0;
        w_state = S_XFER;
      end
      S_DONE: begin
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_mask    <= 4'b0000;
      r_sel     <= 4'b0000;
      r_adr     <= 32'h0;
      r_dat     <= 32'h0;
      r_we      <= 1'b0;
      r_cyc     <= 1'b0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= 32'h0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state;
      r_mask    <= w_mask;
      r_sel     <= w_sel;
      r_adr     <= w_adr;
      r_dat     <= w_dat;
      r_we      <= w_we;
      r_cyc     <= w_cyc;
      r_pready  <= w_pready;
      r_pslverr <= w_pslverr;
      r_prdata  <= w_prdata;
      r_cnt     <= w_cnt;
    end
  end

  assign pready  = r_pready;
  assign prdata  = r_prdata;
  assign pslverr = r_pslverr;
  assign adr_o   = r_adr;
  assign dat_o   = r_dat;
  assign sel_o   = r_sel;
  assign cyc_o   = r_cyc;
  assign stb_o   = r_cyc;
  assign we_o    = r_we;

endmodule

// File: tb/tb_psram_apb_wb_bridge.sv
// tb_psram_apb_wb_bridge
//   Scoreboard bench: the APB driver pushes the expected WB chunks and the
//   expected APB completion into queues. Independent monitors pop and compare
//   whenever the DUT raises cyc_o or pready. A WB responder acks after a
//   configurable delay.
module tb_psram_apb_wb_bridge;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          SL2  = 24;
  localparam int          TO   = 16;

  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic [31:0] paddr = '0, pwdata = '0, dat_i = '0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0, ack_i = 1'b0;
  logic [3:0]  pstrb = '0;
  logic        pready, pslverr, cyc_o, stb_o, we_o;
  logic [31:0] prdata, adr_o, dat_o;
  logic [3:0]  sel_o;

  psram_apb_wb_bridge #(.BASE_ADDR(BASE), .SIZE_LOG2(SL2), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata),
    .pslverr(pslverr), .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .sel_o(sel_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .ack_i(ack_i));

  always #5 clk_i = ~clk_i;

  int unsigned cnt = 0;
  always @(posedge clk_i) cnt <= cnt + 1;

  typedef struct {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] dat;
    bit          first;
  } wb_exp_t;

  // kind: 0 = no WB cycle (pready one cycle after the access phase)
  //       1 = acked (pready one cycle after the last ack)
  //       2 = timeout (pready TO cycles after the chunk's cyc_o rose)
  typedef struct {
    int          kind;
    bit          chk_data;
    logic [31:0] prdata;
    logic        pslverr;
  } rsp_exp_t;

  wb_exp_t  wb_q[$];
  rsp_exp_t rsp_q[$];
  int checks = 0, errors = 0;
  int unsigned acc_cnt = 0, ack_cnt = 0, rise_cnt = 0, fall_cnt = 0;
  int          delay_cfg = 1;
  bit          noack_cfg = 1'b0;
  logic [31:0] rdata_cfg = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // WB responder: acks the chunk after delay_cfg cycles of cyc_o; read data
  // is driven only on the ack cycle, and is random noise otherwise.
  initial begin : responder
    int w;
    w = 0;
    forever begin
      @(negedge clk_i);
      if (ack_i) begin
        ack_i = 1'b0;
        dat_i = $urandom;
        w = 0;
      end else if (cyc_o && !rst_i) begin
        w++;
        if (!noack_cfg && w >= delay_cfg) begin
          ack_i = 1'b1;
          if (!we_o) dat_i = rdata_cfg;
          ack_cnt = cnt;
        end
      end else begin
        w = 0;
        dat_i = $urandom;
      end
    end
  end

  // WB monitor: every rising cyc_o must match the next expected chunk.
  initial begin : wb_mon
    bit pc;
    wb_exp_t e;
    pc = 1'b0;
    forever begin
      @(negedge clk_i);
      if (cyc_o && !pc) begin
        rise_cnt = cnt;
        if (wb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wb_unexpected: cyc_o rose with sel %b, none expected", sel_o);
        end else begin
          e = wb_q.pop_front();
          chk("wb_adr", adr_o, e.adr);
          chk("wb_sel", {28'h0, sel_o}, {28'h0, e.sel});
          chk("wb_we", {31'h0, we_o}, {31'h0, e.we});
          chk("wb_stb", {31'h0, stb_o}, 32'h1);
          if (e.we) chk("wb_dat", dat_o, e.dat);
          if (!e.first) chk("wb_gap", cnt - fall_cnt, 32'd1);
        end
      end
      if (!cyc_o && pc) fall_cnt = cnt;
      pc = cyc_o;
    end
  end

  // APB completion monitor.
  initial begin : rsp_mon
    bit pp;
    rsp_exp_t r;
    int unsigned exp_c;
    pp = 1'b0;
    forever begin
      @(negedge clk_i);
      if (pready) begin
        if (pp) begin
          checks++; errors++;
          $display("FAIL pready_width: pready high for more than one cycle, expected 1");
        end else if (rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pready_unexpected: pready=1 with no transfer pending, expected 0");
        end else begin
          r = rsp_q.pop_front();
          chk("pslverr", {31'h0, pslverr}, {31'h0, r.pslverr});
          if (r.chk_data) chk("prdata", prdata, r.prdata);
          case (r.kind)
            0:       exp_c = acc_cnt + 1;
            1:       exp_c = ack_cnt + 1;
            default: exp_c = rise_cnt + TO;
          endcase
          chk("pready_latency", cnt, exp_c);
        end
      end
      pp = pready;
    end
  end

  // Reference model: push what this APB access should produce.
  task automatic model(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input bit na, input logic [31:0] rd,
                       input bit push_rsp, input int max_chunks);
    bit inwin;
    logic [3:0] m, c, low;
    logic [31:0] wadr;
    rsp_exp_t r;
    int n;
    inwin = (addr - BASE) < (32'd1 << SL2);
    wadr  = ((addr - BASE) & ~32'h3) + BASE;
    r.kind = 1; r.chk_data = 1'b0; r.prdata = rd; r.pslverr = 1'b0;
    if (!inwin) begin
      r.kind = 0; r.pslverr = 1'b1;
    end else if (!wr) begin
      if (na) begin r.kind = 2; r.pslverr = 1'b1; end
      else r.chk_data = 1'b1;
      wb_q.push_back('{adr: wadr, sel: 4'hF, we: 1'b0, dat: data, first: 1'b1});
    end else if (strb == 4'h0) begin
      r.kind = 0;
    end else begin
      m = strb; n = 0;
      while (m != 4'h0 && n < max_chunks) begin
        if (m == 4'hF) c = 4'hF;
        else begin
          low = m & (~m + 4'd1);
          if ((low == 4'b0001 || low == 4'b0100) && (m & (low << 1)) != 4'h0) c = low | (low << 1);
          else c = low;
        end
        wb_q.push_back('{adr: wadr, sel: c, we: 1'b1, dat: data, first: (n == 0)});
        m = m & ~c;
        n++;
      end
    end
    if (push_rsp) rsp_q.push_back(r);
  endtask

  // Setup + access phase; APB inputs are scrambled after the access phase
  // is taken, since the bridge must not look at them again.
  task automatic apb_start(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int dly, input bit na,
                           input logic [31:0] rd);
    delay_cfg = dly; noack_cfg = na; rdata_cfg = rd;
    @(posedge clk_i); #1;
    paddr = addr; pwrite = wr; pwdata = data; pstrb = strb; psel = 1'b1; penable = 1'b0;
    @(posedge clk_i); #1;
    penable = 1'b1;
    @(negedge clk_i);
    acc_cnt = cnt;
    @(posedge clk_i); #1;
    paddr = BASE + ($urandom & 32'h00FF_FFFF); pwdata = $urandom; pstrb = 4'($urandom);
  endtask

  task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] strb, input int dly, input bit na, input logic [31:0] rd);
    int n;
    model(wr, addr, data, strb, na, rd, 1'b1, 8);
    apb_start(wr, addr, data, strb, dly, na, rd);
    n = 0;
    while (!pready && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    if (!pready) begin
      checks++; errors++;
      $display("FAIL apb_wait: pready not seen within 300 cycles, expected a completion");
    end
    @(posedge clk_i); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pstrb = 4'h0;
  endtask

  initial begin : main
    int n;
    repeat (3) @(negedge clk_i);
    chk("rst_pready", {31'h0, pready}, 32'h0);
    chk("rst_pslverr", {31'h0, pslverr}, 32'h0);
    chk("rst_cyc", {31'h0, cyc_o}, 32'h0);
    chk("rst_stb", {31'h0, stb_o}, 32'h0);
    chk("rst_we", {31'h0, we_o}, 32'h0);
    chk("rst_sel", {28'h0, sel_o}, 32'h0);
    chk("rst_adr", adr_o, 32'h0);
    chk("rst_prdata", prdata, 32'h0);
    @(posedge clk_i); #1 rst_i = 1'b0;

    apb(1'b0, 32'h8000_0104, 32'h0, 4'h0, 12, 1'b0, 32'hDEADBEEF);
    apb(1'b1, 32'h8000_0200, 32'h1122_3344, 4'b0110, 3, 1'b0, 32'h0);
    apb(1'b1, 32'h8000_0300, 32'hA5A5_5A5A, 4'b1111, 2, 1'b0, 32'h0);
    apb(1'b1, 32'h8000_0304, 32'h0BAD_F00D, 4'b1011, 1, 1'b0, 32'h0);
    apb(1'b1, 32'h8000_0308, 32'h1234_5678, 4'b0000, 1, 1'b0, 32'h0);
    apb(1'b0, 32'h9000_0000, 32'h0, 4'h0, 1, 1'b0, 32'h0);
    apb(1'b0, 32'h8000_0010, 32'h0, 4'h0, 1, 1'b1, 32'h0);
    apb(1'b0, 32'h80FF_FFFE, 32'h0, 4'h0, 2, 1'b0, 32'hCAFE_0001);
    apb(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 1, 1'b0, 32'h0);
    apb(1'b1, 32'h8100_0000, 32'hFFFF_0000, 4'hF, 1, 1'b0, 32'h0);
    apb(1'b1, 32'h8000_0040, 32'h0102_0304, 4'b1110, 1, 1'b0, 32'h0);
    apb(1'b1, 32'h8000_0044, 32'h0506_0708, 4'b0111, 4, 1'b0, 32'h0);

    // Reset during the gap of a two-chunk write: only the first chunk may
    // appear and no completion may follow.
    model(1'b1, 32'h8000_0500, 32'h5555_AAAA, 4'b0110, 1'b0, 32'h0, 1'b0, 1);
    apb_start(1'b1, 32'h8000_0500, 32'h5555_AAAA, 4'b0110, 2, 1'b0, 32'h0);
    n = 0;
    while (!cyc_o && n < 100) begin @(negedge clk_i); n++; end
    while (cyc_o && n < 100) begin @(negedge clk_i); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL gap_wait: gap cycle not seen within 100 cycles, expected one");
    end
    rst_i = 1'b1;
    #1;
    chk("midrst_cyc", {31'h0, cyc_o}, 32'h0);
    chk("midrst_we", {31'h0, we_o}, 32'h0);
    chk("midrst_sel", {28'h0, sel_o}, 32'h0);
    chk("midrst_adr", adr_o, 32'h0);
    chk("midrst_pready", {31'h0, pready}, 32'h0);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (4) @(negedge clk_i);
    apb(1'b0, 32'h8000_0600, 32'h0, 4'h0, 3, 1'b0, 32'h1357_9BDF);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = BASE + ($urandom & 32'h00FF_FFFF);
      apb(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
          $urandom_range(1, 6), 1'b0, $urandom);
    end

    repeat (5) @(negedge clk_i);
    chk("wb_queue_drained", wb_q.size(), 32'd0);
    chk("rsp_queue_drained", rsp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
